pc_fetch_sequencer: RTL and testbench
=====================================

// Module: pc_fetch_sequencer
// PURPOSE
//  Owns the architectural fetch PC and sequences instruction fetch toward instruction memory.
//  Chooses the next PC: sequential +4, EX-stage jump/branch target, or CSR trap/return target.
//  Uses a valid/ready request and valid response handshake to memory, and a valid/ready handshake to decode.
//  Sits between the CSR unit, the EX stage and IMEM. It replaces the combinational next-PC path in the IF stage.
// PARAMETERS
//  RESET_PC   64'h0   PC fetched first after reset
//  INST_W     32      instruction width
// PORTS
//  clk             in   1       clock, rising edge
//  rst             in   1       asynchronous reset, active-high
//  trap_valid      in   1       CSR redirect (trap entry / xRET) this cycle
//  trap_pc         in   64      CSR redirect target
//  jump_valid      in   1       EX-stage taken jump/branch this cycle
//  jump_pc         in   64      EX-stage target
//  imem_req_valid  out  1       fetch request valid
//  imem_req_addr   out  64      fetch address
//  imem_req_ready  in   1       IMEM accepts request
//  imem_resp_valid in   1       IMEM returns instruction (one per accepted request, in order)
//  imem_resp_inst  in   INST_W  returned instruction
//  if_valid        out  1       instruction presented to decode
//  if_pc           out  64      PC of presented instruction
//  if_inst         out  INST_W  presented instruction
//  if_ready        in   1       decode accepts (low = pipeline stall)
//  flush_if        out  1       one-cycle pulse: redirect taken, discard younger IF/ID work
// BEHAVIOUR
//  Reset (async): state=IDLE, pc=RESET_PC, pend_valid=0, drop=0, all outputs 0. if_pc/if_inst=0.
//  redir = trap_valid | jump_valid. tgt = trap_valid ? trap_pc : jump_pc. Trap beats jump in the same cycle.
//  FSM states: IDLE, REQ, WAIT, HOLD.
//   IDLE: outputs idle. Next cycle -> REQ. A redirect in IDLE loads pc=tgt and asserts flush_if.
//   REQ: imem_req_valid=1, imem_req_addr=pc. Addr is held stable until accepted.
//     If redir and no handshake: pc<=tgt. Addr changes next cycle; the old request was never accepted.
//     If handshake (valid&ready): -> WAIT. If redir in the same cycle: pend<=tgt, drop<=1.
//   WAIT: if redir: pend<=tgt, drop<=1. A later redirect overwrites pend.
//     On imem_resp_valid:
//       drop=1 (or redir this cycle): discard the response, pc<=latest target, clear drop, -> REQ.
//       otherwise: latch inst; if_pc=pc; -> HOLD.
//   HOLD: if_valid=1 with latched pc/inst, held stable until accepted.
//     if_valid&if_ready and no redir: pc<=pc+4 (mod 2^64 wrap), -> REQ.
//     redir (with or without if_ready): instruction dropped, if_valid forced 0 that cycle, pc<=tgt, -> REQ.
//  flush_if = redir in any state (registered-free, same cycle).
//  Latency:
//   - Request accepted in cycle N and response in cycle M gives if_valid in cycle M+1.
//   - Accept at HOLD gives the next request in the following cycle.
//  Responses: exactly one per accepted request. A response outside WAIT is a protocol error and is ignored.
//  PC arithmetic: 64-bit unsigned. No alignment check here; misaligned targets are the CSR unit's job.
//  Reset asserted mid-transaction: state cleared immediately.
//   - An in-flight IMEM response after reset falls in IDLE/REQ and is ignored.
//   - IMEM must be reset together with this block.
// TESTING
//  T1 reset: release rst -> REQ addr=RESET_PC, ready=1, resp 1 cycle later -> if_valid, if_pc=0, next addr=4.
//  T2 stall: hold if_ready=0 5 cycles in HOLD -> if_valid/if_pc/if_inst stable, no new imem request.
//  T3 jump in WAIT: req 0x100 accepted, jump_pc=0x200 before resp -> resp dropped, next addr=0x200, flush_if 1 cycle.
//  T4 trap+jump same cycle in HOLD: trap_pc=0x8000_0000, jump_pc=0x300 -> if_valid=0, next addr=0x8000_0000.
//  T5 backpressure: imem_req_ready=0 3 cycles at 0x40 -> addr stable 0x40; redirect to 0x80 during wait -> addr 0x80.
//  T6 wrap/async reset: pc=64'hFFFF_FFFF_FFFF_FFFC accepted -> next addr 0. rst pulse in WAIT -> outputs 0 immediately, restart at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// Fetch PC owner and instruction-fetch sequencer.
// Picks the next PC (sequential +4, EX jump target, or CSR trap/return target),
// issues one request at a time to IMEM over a valid/ready channel, and presents
// the returned instruction to decode over a valid/ready channel.
module pc_fetch_sequencer #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          INST_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trap_valid,
    input  logic [63:0]       trap_pc,
    input  logic              jump_valid,
    input  logic [63:0]       jump_pc,
    output logic              imem_req_valid,
    output logic [63:0]       imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_inst,
    output logic              if_valid,
    output logic [63:0]       if_pc,
    output logic [INST_W-1:0] if_inst,
    input  logic              if_ready,
    output logic              flush_if
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [63:0]         pc_q, pc_d;
    logic [63:0]         pend_q, pend_d;
    logic                drop_q, drop_d;
    logic [63:0]         if_pc_q, if_pc_d;
    logic [INST_W-1:0]   inst_q, inst_d;

    // A trap outranks a jump arriving in the same cycle.
    logic        redir;
    logic [63:0] tgt;
    assign redir = trap_valid | jump_valid;
    assign tgt   = trap_valid ? trap_pc : jump_pc;

    // Redirect flush is combinational: younger IF/ID work dies in the same cycle.
    assign flush_if       = redir;
    assign imem_req_valid = (state_q == REQ);
    assign imem_req_addr  = (state_q == REQ) ? pc_q : 64'h0;
    assign if_valid       = (state_q == HOLD) && !redir;
    assign if_pc          = if_pc_q;
    assign if_inst        = inst_q;

    // State and datapath registers; reset clears everything at once.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            pend_q  <= 64'h0;
            drop_q  <= 1'b0;
            if_pc_q <= 64'h0;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            drop_q  <= drop_d;
            if_pc_q <= if_pc_d;
            inst_q  <= inst_d;
        end
    end

    // Next-state and next-PC selection.
    always_comb begin
        // NOTE: every variable gets a hold-value default first so no path can infer a latch.
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        drop_d  = drop_q;
        if_pc_d = if_pc_q;
        inst_d  = inst_q;

        unique case (state_q)
            IDLE: begin
                if (redir) pc_d = tgt;
                state_d = REQ;
            end
            REQ: begin
                if (imem_req_ready) begin
                    // Request is in flight; a simultaneous redirect must discard its response.
                    state_d = WAIT;
                    if (redir) begin
                        pend_d = tgt;
                        drop_d = 1'b1;
                    end
                end else if (redir) begin
                    // Unaccepted request can simply be retargeted.
                    pc_d = tgt;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    if (drop_q || redir) begin
                        pc_d    = redir ? tgt : pend_q;
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        inst_d  = imem_resp_inst;
                        if_pc_d = pc_q;
                        state_d = HOLD;
                    end
                end else if (redir) begin
                    pend_d = tgt;
                    drop_d = 1'b1;
                end
            end
            HOLD: begin
                if (redir) begin
                    pc_d    = tgt;
                    state_d = REQ;
                end else if (if_ready) begin
                    pc_d    = pc_q + 64'd4;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: one cycle-by-cycle vector table
// followed by a hand-written asynchronous-reset sequence.
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        trap_valid, jump_valid;
    logic [63:0] trap_pc, jump_pc;
    logic        imem_req_valid, imem_req_ready, imem_resp_valid;
    logic [63:0] imem_req_addr;
    logic [31:0] imem_resp_inst;
    logic        if_valid, if_ready, flush_if;
    logic [63:0] if_pc;
    logic [31:0] if_inst;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_fetch_sequencer #(.RESET_PC(64'h0), .INST_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .trap_valid      (trap_valid),
        .trap_pc         (trap_pc),
        .jump_valid      (jump_valid),
        .jump_pc         (jump_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_inst  (imem_resp_inst),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_inst         (if_inst),
        .if_ready        (if_ready),
        .flush_if        (flush_if)
    );

    typedef struct {
        bit          tv;  logic [63:0] tp;
        bit          jv;  logic [63:0] jp;
        bit          rr;  bit          rv;  logic [31:0] ri;  bit ir;
        bit          e_rv; logic [63:0] e_ra;
        bit          e_iv; logic [63:0] e_pc; logic [31:0] e_in;
        bit          e_fl;
    } vec_t;

    localparam int NV = 34;
    vec_t vecs [NV];

    function automatic vec_t mk(input bit tv, input logic [63:0] tp, input bit jv, input logic [63:0] jp,
                                input bit rr, input bit rv, input logic [31:0] ri, input bit ir,
                                input bit e_rv, input logic [63:0] e_ra, input bit e_iv,
                                input logic [63:0] e_pc, input logic [31:0] e_in, input bit e_fl);
        vec_t v;
        v.tv = tv; v.tp = tp; v.jv = jv; v.jp = jp;
        v.rr = rr; v.rv = rv; v.ri = ri; v.ir = ir;
        v.e_rv = e_rv; v.e_ra = e_ra; v.e_iv = e_iv; v.e_pc = e_pc; v.e_in = e_in; v.e_fl = e_fl;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        trap_valid = v.tv; trap_pc = v.tp;
        jump_valid = v.jv; jump_pc = v.jp;
        imem_req_ready = v.rr; imem_resp_valid = v.rv; imem_resp_inst = v.ri;
        if_ready = v.ir;
    endtask

    task automatic idle_inputs();
        trap_valid = 0; trap_pc = '0; jump_valid = 0; jump_pc = '0;
        imem_req_ready = 0; imem_resp_valid = 0; imem_resp_inst = '0; if_ready = 0;
    endtask

    localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

    initial begin
        //             tv tp            jv jp            rr rv ri            ir  e_rv e_ra          e_iv e_pc  e_in          fl
        // T1: reset fetch, first instruction, sequential +4
        vecs[0]  = mk(0, 0,            0, 0,            0, 0, 0,            0,  0, 0,            0, 0,     0,            0);
        vecs[1]  = mk(0, 0,            0, 0,            1, 0, 0,            0,  1, 0,            0, 0,     0,            0);
        vecs[2]  = mk(0, 0,            0, 0,            0, 1, 32'hAAAA0001, 0,  0, 0,            0, 0,     0,            0);
        vecs[3]  = mk(0, 0,            0, 0,            0, 0, 0,            1,  0, 0,            1, 0,     32'hAAAA0001, 0);
        vecs[4]  = mk(0, 0,            0, 0,            1, 0, 0,            0,  1, 4,            0, 0,     0,            0);
        vecs[5]  = mk(0, 0,            0, 0,            0, 1, 32'h11110004, 0,  0, 0,            0, 0,     0,            0);
        // T2: decode stall for 5 cycles
        for (int i = 6; i <= 10; i++)
            vecs[i] = mk(0, 0,         0, 0,            1, 0, 0,            0,  0, 0,            1, 4,     32'h11110004, 0);
        vecs[11] = mk(0, 0,            0, 0,            0, 0, 0,            1,  0, 0,            1, 4,     32'h11110004, 0);
        // jump before acceptance retargets the request to 0x100
        vecs[12] = mk(0, 0,            1, 64'h100,      0, 0, 0,            0,  1, 8,            0, 0,     0,            1);
        // T3: jump while waiting for the 0x100 response
        vecs[13] = mk(0, 0,            0, 0,            1, 0, 0,            0,  1, 64'h100,      0, 0,     0,            0);
        vecs[14] = mk(0, 0,            1, 64'h200,      0, 0, 0,            0,  0, 0,            0, 0,     0,            1);
        vecs[15] = mk(0, 0,            0, 0,            0, 1, 32'hDEAD0100, 1,  0, 0,            0, 0,     0,            0);
        vecs[16] = mk(0, 0,            0, 0,            1, 0, 0,            0,  1, 64'h200,      0, 0,     0,            0);
        vecs[17] = mk(0, 0,            0, 0,            0, 1, 32'h22220200, 0,  0, 0,            0, 0,     0,            0);
        // T4: trap and jump together in HOLD, trap wins
        vecs[18] = mk(1, 64'h8000_0000, 1, 64'h300,     0, 0, 0,            1,  0, 0,            0, 0,     0,            1);
        // T5: backpressure at 0x40, then redirect to 0x80 while unaccepted
        vecs[19] = mk(0, 0,            1, 64'h40,       0, 0, 0,            0,  1, 64'h8000_0000, 0, 0,    0,            1);
        vecs[20] = mk(0, 0,            0, 0,            0, 0, 0,            0,  1, 64'h40,       0, 0,     0,            0);
        vecs[21] = mk(0, 0,            0, 0,            0, 0, 0,            0,  1, 64'h40,       0, 0,     0,            0);
        vecs[22] = mk(0, 0,            0, 0,            0, 0, 0,            0,  1, 64'h40,       0, 0,     0,            0);
        vecs[23] = mk(1, 64'h80,       0, 0,            0, 0, 0,            0,  1, 64'h40,       0, 0,     0,            1);
        vecs[24] = mk(0, 0,            0, 0,            1, 0, 0,            0,  1, 64'h80,       0, 0,     0,            0);
        vecs[25] = mk(0, 0,            0, 0,            0, 1, 32'h33330080, 0,  0, 0,            0, 0,     0,            0);
        vecs[26] = mk(0, 0,            0, 0,            0, 0, 0,            1,  0, 0,            1, 64'h80, 32'h33330080, 0);
        // redirect coinciding with acceptance: the response must be dropped
        vecs[27] = mk(0, 0,            1, TOP,          1, 0, 0,            0,  1, 64'h84,       0, 0,     0,            1);
        vecs[28] = mk(0, 0,            0, 0,            0, 1, 32'h0BAD0084, 1,  0, 0,            0, 0,     0,            0);
        // T6: fetch at top of address space, +4 wraps to 0
        vecs[29] = mk(0, 0,            0, 0,            1, 0, 0,            0,  1, TOP,          0, 0,     0,            0);
        vecs[30] = mk(0, 0,            0, 0,            0, 1, 32'h4444FFFC, 0,  0, 0,            0, 0,     0,            0);
        vecs[31] = mk(0, 0,            0, 0,            0, 0, 0,            1,  0, 0,            1, TOP,   32'h4444FFFC, 0);
        vecs[32] = mk(0, 0,            0, 0,            1, 0, 0,            0,  1, 0,            0, 0,     0,            0);
        vecs[33] = mk(0, 0,            0, 0,            0, 0, 0,            0,  0, 0,            0, 0,     0,            0);

        // Reset state
        rst = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);
        check("rst req_valid", {63'h0, imem_req_valid}, 64'h0);
        check("rst req_addr",  imem_req_addr, 64'h0);
        check("rst if_valid",  {63'h0, if_valid}, 64'h0);
        check("rst if_pc",     if_pc, 64'h0);
        check("rst if_inst",   {32'h0, if_inst}, 64'h0);
        check("rst flush_if",  {63'h0, flush_if}, 64'h0);

        // Table-driven cycle vectors; rst released together with vector 0
        for (int i = 0; i < NV; i++) begin
            if (i != 0) @(negedge clk);
            rst = 1'b0;
            drive(vecs[i]);
            #1;
            check($sformatf("v%0d req_valid", i), {63'h0, imem_req_valid}, {63'h0, vecs[i].e_rv});
            if (vecs[i].e_rv)
                check($sformatf("v%0d req_addr", i), imem_req_addr, vecs[i].e_ra);
            check($sformatf("v%0d if_valid", i), {63'h0, if_valid}, {63'h0, vecs[i].e_iv});
            if (vecs[i].e_iv) begin
                check($sformatf("v%0d if_pc", i), if_pc, vecs[i].e_pc);
                check($sformatf("v%0d if_inst", i), {32'h0, if_inst}, {32'h0, vecs[i].e_in});
            end
            check($sformatf("v%0d flush_if", i), {63'h0, flush_if}, {63'h0, vecs[i].e_fl});
        end

        // Async reset in WAIT: outputs clear before any clock edge
        @(negedge clk);
        idle_inputs();
        #2 rst = 1'b1;
        #1;
        check("async rst req_valid", {63'h0, imem_req_valid}, 64'h0);
        check("async rst if_pc",     if_pc, 64'h0);
        check("async rst if_valid",  {63'h0, if_valid}, 64'h0);

        // Stray response in IDLE is ignored
        @(negedge clk);
        rst = 1'b0;
        imem_resp_valid = 1; imem_resp_inst = 32'h5555_5555;
        #1;
        check("post rst idle req_valid", {63'h0, imem_req_valid}, 64'h0);
        // Stray response in REQ is ignored; restart at RESET_PC
        @(negedge clk);
        #1;
        check("restart req_valid", {63'h0, imem_req_valid}, 64'h1);
        check("restart req_addr",  imem_req_addr, 64'h0);
        @(negedge clk);
        imem_resp_valid = 0; imem_req_ready = 1;
        #1;
        check("restart addr held", imem_req_addr, 64'h0);
        @(negedge clk);
        imem_req_ready = 0; imem_resp_valid = 1; imem_resp_inst = 32'h6666_0000;
        #1;
        check("restart wait req_valid", {63'h0, imem_req_valid}, 64'h0);
        @(negedge clk);
        imem_resp_valid = 0; if_ready = 1;
        #1;
        check("restart if_valid", {63'h0, if_valid}, 64'h1);
        check("restart if_pc",    if_pc, 64'h0);
        check("restart if_inst",  {32'h0, if_inst}, 64'h6666_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
